undithering_filter: RTL and testbench



---
 rtl/undithering_filter.sv | 166 ++++++++++++++++
 tb/tb_undithering_filter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/undithering_filter.sv
`timescale 1ns/1ps
// 2x2 box-average undithering of a 4-bit RGB raster stream to 8 bits; one line buffer; 1-cycle latency, in_ready = !out_valid || out_ready.
// Optional macro UNDITHER_BYPASS_EN adds a bypass input that replicates the input nibble instead of filtering.
module undithering_filter #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int BIT_IN     = 4,
  parameter int BIT_OUT    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sof,
  input  logic [BIT_IN-1:0]  R_in,
  input  logic [BIT_IN-1:0]  G_in,
  input  logic [BIT_IN-1:0]  B_in,
`ifdef UNDITHER_BYPASS_EN
  input  logic               bypass,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sof,
  output logic               out_eol,
  output logic [BIT_OUT-1:0] R_out,
  output logic [BIT_OUT-1:0] G_out,
  output logic [BIT_OUT-1:0] B_out
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int SW = BIT_IN + 2;
  localparam int SH = BIT_OUT - BIT_IN - 2;

  // Channel order in packed pixels: [2]=R, [1]=G, [0]=B.
  typedef logic [2:0][BIT_IN-1:0]  pix_t;
  typedef logic [2:0][BIT_OUT-1:0] opix_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  pix_t          left_q, left_d;
  pix_t          ul_q, ul_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sof_q, out_sof_d;
  logic          out_eol_q, out_eol_d;
  opix_t         out_pix_q, out_pix_d;
  pix_t          linebuf_q [IMG_WIDTH];

  logic                accept;
  pix_t                cur, nb_l, nb_u, nb_ul;
  logic [CW-1:0]       eff_col;
  logic [RW-1:0]       eff_row;
  logic [2:0][SW-1:0]  sum;
  opix_t               filt;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign cur      = {R_in, G_in, B_in};

`ifdef UNDITHER_BYPASS_EN
  localparam int NREP = BIT_OUT / BIT_IN + 1;

  function automatic logic [BIT_OUT-1:0] replicate(input logic [BIT_IN-1:0] nib);
    logic [NREP*BIT_IN-1:0] rep;
    rep = {NREP{nib}};
    return rep[NREP*BIT_IN-1 -: BIT_OUT];
  endfunction
`endif

  // A start-of-frame pixel is placed at the origin before neighbours are chosen.
  always_comb begin
    eff_col = in_sof ? '0 : col_q;
    eff_row = in_sof ? '0 : row_q;
    nb_l    = (eff_col == '0) ? cur : left_q;
    nb_u    = (eff_row == '0) ? cur : linebuf_q[eff_col];
    if (eff_row == '0) begin
      nb_ul = nb_l;
    end else if (eff_col == '0) begin
      nb_ul = nb_u;
    end else begin
      nb_ul = ul_q;
    end
  end

  always_comb begin
    sum  = '0;
    filt = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum[ch]  = SW'(cur[ch]) + SW'(nb_l[ch]) + SW'(nb_u[ch]) + SW'(nb_ul[ch]);
      filt[ch] = BIT_OUT'(sum[ch]) << SH;
    end
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    left_d      = left_q;
    ul_d        = ul_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_eol_d   = out_eol_q;
    out_pix_d   = out_pix_q;
    if (accept) begin
      left_d      = cur;
      // This pixel's above value is the next pixel's above-left.
      ul_d        = nb_u;
      out_valid_d = 1'b1;
      out_sof_d   = (eff_col == '0) && (eff_row == '0);
      out_eol_d   = (eff_col == CW'(IMG_WIDTH - 1));
      out_pix_d   = filt;
`ifdef UNDITHER_BYPASS_EN
      if (bypass) begin
        for (int ch = 0; ch < 3; ch++) begin
          out_pix_d[ch] = replicate(cur[ch]);
        end
      end
`endif
      if (eff_col == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (eff_row == RW'(IMG_HEIGHT - 1)) ? '0 : eff_row + RW'(1);
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      left_q      <= '0;
      ul_q        <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      out_pix_q   <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      left_q      <= left_d;
      ul_q        <= ul_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eol_q   <= out_eol_d;
      out_pix_q   <= out_pix_d;
    end
  end

  // Line buffer is never cleared; row 0 never reads it.
  always_ff @(posedge clk) begin
    if (rst_n && accept) begin
      linebuf_q[eff_col] <= cur;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
  assign out_eol   = out_eol_q;
  assign R_out     = out_pix_q[2];
  assign G_out     = out_pix_q[1];
  assign B_out     = out_pix_q[0];

endmodule

// File: tb/tb_undithering_filter.sv
`timescale 1ns/1ps
// Scoreboard bench for undithering_filter on a reduced 16x6 frame; expectations come from a whole-row reference model.
module tb_undithering_filter;

  localparam int W = 16;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_sof = 1'b0;
  logic [3:0] R_in = '0, G_in = '0, B_in = '0;
`ifdef UNDITHER_BYPASS_EN
  logic       bypass = 1'b0;
`endif
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_sof, out_eol;
  logic [7:0] R_out, G_out, B_out;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       sof;
    logic       eol;
  } exp_t;

  exp_t        sb[$];
  exp_t        e, got;
  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          out_seen = 0, eol_seen = 0, sof_seen = 0, eol_pos = 0, sof_pos = 0;
  int          m_col = 0, m_row = 0;
  logic [11:0] cur_row [W];
  logic [11:0] prev_row [W];

  undithering_filter #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BIT_IN(4), .BIT_OUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .R_in(R_in), .G_in(G_in), .B_in(B_in),
`ifdef UNDITHER_BYPASS_EN
    .bypass(bypass),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol),
    .R_out(R_out), .G_out(G_out), .B_out(B_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: neighbours taken from complete current/previous row images.
  task automatic model_push(input logic [3:0] r, g, b, input logic sof, input logic byp);
    logic [11:0] cur;
    logic [3:0]  c, l, u, ul;
    logic [7:0]  o [3];
    int          s;
    exp_t        ex;
    if (sof) begin m_col = 0; m_row = 0; end
    cur = {r, g, b};
    for (int ch = 0; ch < 3; ch++) begin
      c  = cur[ch*4 +: 4];
      l  = (m_col == 0) ? c : cur_row[m_col-1][ch*4 +: 4];
      u  = (m_row == 0) ? c : prev_row[m_col][ch*4 +: 4];
      ul = (m_row == 0) ? l : ((m_col == 0) ? u : prev_row[m_col-1][ch*4 +: 4]);
      s  = int'(c) + int'(l) + int'(u) + int'(ul);
      o[ch] = byp ? {c, c} : 8'(s * 4);
    end
    ex.r = o[2]; ex.g = o[1]; ex.b = o[0];
    ex.sof = (m_col == 0) && (m_row == 0);
    ex.eol = (m_col == W - 1);
    sb.push_back(ex);
    cur_row[m_col] = cur;
    if (m_col == W - 1) begin
      prev_row = cur_row;
      m_col = 0;
      m_row = (m_row == H - 1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  // Returns just after the posedge on which the pixel is accepted.
  task automatic send(input logic [3:0] r, g, b, input logic sof, input logic byp);
    int budget = 0;
    @(negedge clk);
    in_valid = 1'b1; R_in = r; G_in = g; B_in = b; in_sof = sof;
`ifdef UNDITHER_BYPASS_EN
    bypass = byp;
`endif
    #1;
    while (!in_ready && budget < 200) begin
      @(negedge clk); #1; budget++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, budget);
      in_valid = 1'b0;
      return;
    end
    model_push(r, g, b, sof, byp);
    @(posedge clk);
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  always begin
    @(negedge clk); #2;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      got = {R_out, G_out, B_out, out_sof, out_eol};
      if (sb.size() == 0) begin
        $display("FAIL unexpected_output: got %h, required no output", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) $display("FAIL pixel_%0d: got %h, required %h", out_seen, got, e);
        else passed++;
      end
      out_seen++;
      if (out_eol) begin eol_seen++; eol_pos = out_seen; end
      if (out_sof) begin sof_seen++; sof_pos = out_seen; end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks += 7;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", out_valid); else passed++;
    if (out_sof !== 1'b0) $display("FAIL rst_out_sof: got %b, required 0", out_sof); else passed++;
    if (out_eol !== 1'b0) $display("FAIL rst_out_eol: got %b, required 0", out_eol); else passed++;
    if (R_out !== 8'h00) $display("FAIL rst_R_out: got %h, required 00", R_out); else passed++;
    if (G_out !== 8'h00) $display("FAIL rst_G_out: got %h, required 00", G_out); else passed++;
    if (B_out !== 8'h00) $display("FAIL rst_B_out: got %h, required 00", B_out); else passed++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b, required 1", in_ready); else passed++;
  endtask

  task automatic test_first_pixel();
    send(4'hA, 4'h3, 4'h0, 1'b0, 1'b0);
    #1;
    checks += 4;
    if (out_valid !== 1'b1) $display("FAIL first_latency: out_valid=%b, required 1", out_valid); else passed++;
    if (R_out !== 8'hA0) $display("FAIL first_R: got %h, required a0", R_out); else passed++;
    if (G_out !== 8'h30) $display("FAIL first_G: got %h, required 30", G_out); else passed++;
    if (B_out !== 8'h00) $display("FAIL first_B: got %h, required 00", B_out); else passed++;
    drain();
  endtask

  task automatic test_stripes();
    logic [3:0] v;
    for (int c = 0; c < W; c++) begin
      v = (c % 2 == 1) ? 4'hF : 4'h0;
      send(v, v, v, c == 0, 1'b0);
    end
    send(4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    send(4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    #1;
    checks += 2;
    if (R_out !== 8'h78) $display("FAIL stripe_R: got %h, required 78", R_out); else passed++;
    if (B_out !== 8'h78) $display("FAIL stripe_B: got %h, required 78", B_out); else passed++;
    drain();
  endtask

  task automatic test_flat_field();
    int c0, e0, s0, o0;
    e0 = eol_seen; s0 = sof_seen; o0 = out_seen;
    send(4'h8, 4'h8, 4'h8, 1'b1, 1'b0);
    c0 = cyc;
    for (int i = 1; i < W * H; i++) send(4'h8, 4'h8, 4'h8, 1'b0, 1'b0);
    checks++;
    if (cyc - c0 !== W * H - 1) $display("FAIL flat_throughput: %0d cycles, required %0d", cyc - c0, W * H - 1); else passed++;
    drain();
    checks += 3;
    if (out_seen - o0 !== W * H) $display("FAIL flat_count: got %0d, required %0d", out_seen - o0, W * H); else passed++;
    if (eol_seen - e0 !== H) $display("FAIL flat_eol_count: got %0d, required %0d", eol_seen - e0, H); else passed++;
    if (sof_seen - s0 !== 1) $display("FAIL flat_sof_count: got %0d, required 1", sof_seen - s0); else passed++;
  endtask

  task automatic test_back_to_back_backpressure();
    int o0;
    logic [23:0] held;
    o0 = out_seen;
    fork
      begin
        for (int k = 0; k < 2 * W; k++)
          send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), k == 0, 1'b0);
      end
      begin
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        #1;
        held = {R_out, G_out, B_out};
        for (int s = 0; s < 3; s++) begin
          if (s > 0) begin @(negedge clk); #1; end
          checks += 3;
          if (in_ready !== 1'b0) $display("FAIL bp_in_ready_%0d: got %b, required 0", s, in_ready); else passed++;
          if (out_valid !== 1'b1) $display("FAIL bp_out_valid_%0d: got %b, required 1", s, out_valid); else passed++;
          if ({R_out, G_out, B_out} !== held) $display("FAIL bp_hold_%0d: got %h, required %h", s, {R_out, G_out, B_out}, held); else passed++;
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    checks += 2;
    if (out_seen - o0 !== 2 * W) $display("FAIL bp_count: got %0d, required %0d", out_seen - o0, 2 * W); else passed++;
    if (sb.size() !== 0) $display("FAIL bp_pending: got %0d, required 0", sb.size()); else passed++;
  endtask

  task automatic test_sof_midframe();
    for (int i = 0; i < 3 * W + 10; i++)
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), i == 0, 1'b0);
    send(4'h5, 4'hC, 4'h9, 1'b1, 1'b0);
    #1;
    checks += 2;
    if (out_sof !== 1'b1) $display("FAIL midsof_sof: got %b, required 1", out_sof); else passed++;
    if (R_out !== 8'h50) $display("FAIL midsof_R: got %h, required 50", R_out); else passed++;
    for (int i = 0; i < W; i++)
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 1'b0);
    drain();
    checks++;
    if (eol_pos - sof_pos !== W - 1) $display("FAIL midsof_eol_gap: got %0d, required %0d", eol_pos - sof_pos, W - 1); else passed++;
  endtask

  task automatic test_reset_midline();
    for (int i = 0; i < 5; i++) send(4'h3, 4'h3, 4'h3, i == 0, 1'b0);
    drain();
    @(negedge clk);
    out_ready = 1'b0;
    send(4'h7, 4'h7, 4'h7, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b, required 0", out_valid); else passed++;
    if (sb.size() !== 1) $display("FAIL midrst_pending: got %0d, required 1", sb.size()); else passed++;
    sb.delete();
    m_col = 0; m_row = 0;
    out_ready = 1'b1;
    send(4'h6, 4'h2, 4'hE, 1'b0, 1'b0);
    #1;
    checks += 2;
    if (out_sof !== 1'b1) $display("FAIL midrst_sof: got %b, required 1", out_sof); else passed++;
    if (G_out !== 8'h20) $display("FAIL midrst_G: got %h, required 20", G_out); else passed++;
    drain();
  endtask

`ifdef UNDITHER_BYPASS_EN
  task automatic test_bypass();
    send(4'hF, 4'hA, 4'h3, 1'b1, 1'b1);
    #1;
    checks += 3;
    if (R_out !== 8'hFF) $display("FAIL byp_R: got %h, required ff", R_out); else passed++;
    if (G_out !== 8'hAA) $display("FAIL byp_G: got %h, required aa", G_out); else passed++;
    if (B_out !== 8'h33) $display("FAIL byp_B: got %h, required 33", B_out); else passed++;
    for (int i = 0; i < W + 2; i++)
      send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, i[0]);
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_first_pixel();
    test_stripes();
    test_flat_field();
    test_back_to_back_backpressure();
    test_sof_midframe();
    test_reset_midline();
`ifdef UNDITHER_BYPASS_EN
    test_bypass();
`endif
    checks++;
    if (sb.size() !== 0) $display("FAIL final_pending: got %0d, required 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
